// File: rtl/jedro_1_sig_monitor_pkg.sv
// Shared types and control-cell layout for the signature monitor.
package jedro_1_sig_monitor_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DUMP_REQ,
        ST_DUMP_WAIT,
        ST_DUMP_OUT,
        ST_DONE
    } state_e;

    localparam int unsigned SIG_START_OFS = 1;
    localparam int unsigned SIG_END_OFS   = 2;
    localparam int unsigned HALT_OFS      = 3;

    // Byte address of a control cell counted down from the top of memory.
    function automatic logic [31:0] cell_addr(input int unsigned mem_words, input int unsigned ofs);
        return 32'((mem_words - ofs) << 2);
    endfunction

endpackage

// File: rtl/jedro_1_sig_monitor_cnt.sv
// Saturating cycle counter with enable, clear and terminal-count flag.
module jedro_1_sig_monitor_cnt #(
    parameter logic [31:0] TC_VAL = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    output logic [31:0] cnt_o,
    output logic        tc_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Flags the cycle in which the count steps onto the terminal value.
    assign tc_o  = (cnt_d == TC_VAL) && (cnt_q != TC_VAL);
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jedro_1_sig_monitor.sv
// Snoops a CPU data bus for signature/halt control writes, then streams the
// signature region out of memory one word at a time.
//
// state     | meaning
// RUN       | count cycles, snoop control cells, wait for halt or timeout
// DUMP_REQ  | issue one memory read at ptr_q
// DUMP_WAIT | wait for read data
// DUMP_OUT  | present word on the stream until accepted
// DONE      | dump finished, idle until reset
module jedro_1_sig_monitor
    import jedro_1_sig_monitor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MEM_SIZE_WORDS  = 1 << 19,
    parameter int unsigned TIMEOUT         = 1000000,
    parameter int unsigned DUMP_ON_TIMEOUT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  snoop_stb_i,
    input  logic [3:0]            snoop_we_i,
    input  logic [ADDR_WIDTH-1:0] snoop_addr_i,
    input  logic [DATA_WIDTH-1:0] snoop_wdata_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  sig_valid_o,
    input  logic                  sig_ready_i,
    output logic [DATA_WIDTH-1:0] sig_data_o,
    output logic                  sig_last_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [31:0]           cycle_cnt_o
);

    localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(cell_addr(MEM_SIZE_WORDS, SIG_START_OFS));
    localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(cell_addr(MEM_SIZE_WORDS, SIG_END_OFS));
    localparam logic [ADDR_WIDTH-1:0] HALT_A  = ADDR_WIDTH'(cell_addr(MEM_SIZE_WORDS, HALT_OFS));
    localparam bit DUMP_TO = (DUMP_ON_TIMEOUT != 0);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   start_q, end_q, ptr_q, mem_addr_q;
    logic [DATA_WIDTH-1:0]   sig_data_q;
    logic                    mem_req_q, sig_valid_q, sig_last_q, done_q, timeout_q;

    logic                    run, snoop_wr, halt_req, tc, can_dump, is_last;
    logic [ADDR_WIDTH-1:0]   wdata_aligned, ptr_next;

    assign run           = (state_q == ST_RUN);
    assign snoop_wr      = snoop_stb_i && (snoop_we_i == 4'b1111);
    assign halt_req      = snoop_wr && (snoop_addr_i == HALT_A) && (snoop_wdata_i == DATA_WIDTH'(1));
    assign wdata_aligned = ADDR_WIDTH'(snoop_wdata_i) & ~ADDR_WIDTH'(3);
    assign can_dump      = (start_q < end_q);
    assign ptr_next      = ptr_q + ADDR_WIDTH'(4);
    // Extra bit so a region ending near the top of the address space still terminates.
    assign is_last       = ({1'b0, ptr_q} + (ADDR_WIDTH + 1)'(4)) >= {1'b0, end_q};

    jedro_1_sig_monitor_cnt #(
        .TC_VAL (32'(TIMEOUT - 1))
    ) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (run),
        .clr_i (1'b0),
        .cnt_o (cycle_cnt_o),
        .tc_o  (tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            start_q     <= '0;
            end_q       <= '0;
            ptr_q       <= '0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            sig_data_q  <= '0;
            sig_valid_q <= 1'b0;
            sig_last_q  <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (snoop_wr && (snoop_addr_i == START_A)) start_q <= wdata_aligned;
                    if (snoop_wr && (snoop_addr_i == END_A))   end_q   <= wdata_aligned;
                    if (halt_req || tc) begin
                        // A halt in the expiry cycle takes precedence over the timeout.
                        timeout_q <= !halt_req;
                        if (can_dump && (halt_req || DUMP_TO)) begin
                            state_q    <= ST_DUMP_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= start_q;
                            ptr_q      <= start_q;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DUMP_REQ: begin
                    mem_req_q  <= 1'b0;
                    mem_addr_q <= '0;
                    state_q    <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    if (mem_rvalid_i) begin
                        sig_data_q  <= mem_rdata_i;
                        sig_valid_q <= 1'b1;
                        sig_last_q  <= is_last;
                        state_q     <= ST_DUMP_OUT;
                    end
                end
                ST_DUMP_OUT: begin
                    if (sig_ready_i) begin
                        sig_valid_q <= 1'b0;
                        sig_last_q  <= 1'b0;
                        sig_data_q  <= '0;
                        ptr_q       <= ptr_next;
                        if (sig_last_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_DUMP_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= ptr_next;
                        end
                    end
                end
                ST_DONE: state_q <= ST_DONE;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign sig_valid_o = sig_valid_q;
    assign sig_data_o  = sig_data_q;
    assign sig_last_o  = sig_last_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_jedro_1_sig_monitor.sv
// Bench for jedro_1_sig_monitor: randomized dumps against a memory/stream model.
module tb_jedro_1_sig_monitor;

    localparam int          MEMW    = 1 << 19;
    localparam int          TO      = 50;
    localparam logic [31:0] A_START = 32'((MEMW - 1) * 4);
    localparam logic [31:0] A_END   = 32'((MEMW - 2) * 4);
    localparam logic [31:0] A_HALT  = 32'((MEMW - 3) * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic        snoop_stb = 1'b0;
    logic [3:0]  snoop_we = 4'b0;
    logic [31:0] snoop_addr = '0, snoop_wdata = '0;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        sig_ready;

    logic        mem_req_o, sig_valid_o, sig_last_o, done_o, timeout_o;
    logic [31:0] mem_addr_o, sig_data_o, cycle_cnt_o;
    logic        nd_mem_req_o, nd_sig_valid_o, nd_sig_last_o, nd_done_o, nd_timeout_o;
    logic [31:0] nd_mem_addr_o, nd_sig_data_o, nd_cycle_cnt_o;

    int checks = 0, failures = 0;
    logic [31:0] seed = 32'h1234_5678;
    logic [31:0] mem_ovr [logic [31:0]];
    int mem_lat = 1, rdy_delay = 0, nd_req = 0, stab_err = 0;
    logic [31:0] got_d [$];
    logic        got_l [$];
    logic [31:0] req_q [$];
    logic        stab_wait = 1'b0;
    logic [31:0] stab_data;
    logic        stab_last;

    always #5 clk = ~clk;

    jedro_1_sig_monitor #(.TIMEOUT(TO), .DUMP_ON_TIMEOUT(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .snoop_stb_i(snoop_stb), .snoop_we_i(snoop_we),
        .snoop_addr_i(snoop_addr), .snoop_wdata_i(snoop_wdata),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .sig_valid_o(sig_valid_o), .sig_ready_i(sig_ready), .sig_data_o(sig_data_o),
        .sig_last_o(sig_last_o), .done_o(done_o), .timeout_o(timeout_o), .cycle_cnt_o(cycle_cnt_o));

    jedro_1_sig_monitor #(.TIMEOUT(TO), .DUMP_ON_TIMEOUT(0)) u_dut_nd (
        .clk_i(clk), .rst_i(rst), .snoop_stb_i(snoop_stb), .snoop_we_i(snoop_we),
        .snoop_addr_i(snoop_addr), .snoop_wdata_i(snoop_wdata),
        .mem_req_o(nd_mem_req_o), .mem_addr_o(nd_mem_addr_o),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .sig_valid_o(nd_sig_valid_o), .sig_ready_i(sig_ready), .sig_data_o(nd_sig_data_o),
        .sig_last_o(nd_sig_last_o), .done_o(nd_done_o), .timeout_o(nd_timeout_o), .cycle_cnt_o(nd_cycle_cnt_o));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // Memory: answers each read after mem_lat cycles; junk data while not valid.
    initial begin : mem_model
        logic [31:0] a;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_req_o) begin
                a = mem_addr_o;
                repeat (mem_lat) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(a);
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
    end

    // Consumer: holds ready low rdy_delay cycles after each word appears.
    initial begin : rdy_drv
        int w;
        w = 0;
        sig_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (sig_valid_o && !sig_ready) begin
                if (w >= rdy_delay) sig_ready = 1'b1;
                else w++;
            end else begin
                sig_ready = 1'b0;
                w = 0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                stab_wait = 1'b0;
            end else begin
                if (mem_req_o) req_q.push_back(mem_addr_o);
                if (nd_mem_req_o) nd_req++;
                if (stab_wait && (!sig_valid_o || sig_data_o !== stab_data || sig_last_o !== stab_last))
                    stab_err++;
                if (sig_valid_o && sig_ready) begin
                    got_d.push_back(sig_data_o);
                    got_l.push_back(sig_last_o);
                end
                stab_wait = sig_valid_o && !sig_ready;
                stab_data = sig_data_o;
                stab_last = sig_last_o;
            end
        end
    end

    task automatic snoop_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        snoop_stb = 1'b1; snoop_addr = a; snoop_wdata = d; snoop_we = we;
        @(posedge clk); #1;
        snoop_stb = 1'b0; snoop_we = 4'b0; snoop_addr = $urandom; snoop_wdata = $urandom;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, sig_last_o, done_o, timeout_o, cycle_cnt_o,
             nd_mem_req_o, nd_sig_valid_o, nd_done_o, nd_timeout_o, nd_cycle_cnt_o} !== '0) begin
            failures++;
            $display("FAIL %s_reset_outputs: req=%0b addr=%0h valid=%0b data=%0h last=%0b done=%0b to=%0b cnt=%0d, required all 0",
                     name, mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, sig_last_o, done_o, timeout_o, cycle_cnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        got_d.delete(); got_l.delete(); req_q.delete();
        nd_req = 0; stab_err = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done_o && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!done_o) begin
            failures++;
            $display("FAIL %s_done: done_o=%0b after %0d cycles, required 1", name, done_o, n);
        end
    endtask

    // Reference: every word address in [start, end) with low bits cleared, in order.
    task automatic check_sig(input string name, input logic [31:0] s_raw, input logic [31:0] e_raw);
        logic [31:0] s, e, a;
        int n;
        s = s_raw & ~32'd3;
        e = e_raw & ~32'd3;
        n = (s < e) ? int'((e - s) / 4) : 0;
        checks++;
        if (got_d.size() != n || req_q.size() != n) begin
            failures++;
            $display("FAIL %s_count: words=%0d reads=%0d, required %0d", name, got_d.size(), req_q.size(), n);
        end
        for (int i = 0; i < n && i < got_d.size() && i < req_q.size(); i++) begin
            a = s + 32'(4 * i);
            checks++;
            if (got_d[i] !== mem_word(a) || got_l[i] !== (i == n - 1) || req_q[i] !== a) begin
                failures++;
                $display("FAIL %s_word%0d: data=%0h last=%0b addr=%0h, required data=%0h last=%0b addr=%0h",
                         name, i, got_d[i], got_l[i], req_q[i], mem_word(a), (i == n - 1), a);
            end
        end
    endtask

    task automatic test_reset();
        int k;
        do_reset("reset");
        k = $urandom_range(3, 20);
        repeat (k) @(posedge clk);
        #1;
        checks++;
        if (cycle_cnt_o !== 32'(k) || done_o !== 1'b0 || timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_count: cnt=%0d done=%0b to=%0b, required cnt=%0d done=0 to=0", cycle_cnt_o, done_o, timeout_o, k);
        end
    endtask

    task automatic test_basic();
        mem_ovr[32'h100] = 32'hA; mem_ovr[32'h104] = 32'hB; mem_ovr[32'h108] = 32'hC;
        rdy_delay = 0; mem_lat = 1;
        do_reset("basic");
        snoop_write(A_START, 32'h100, 4'hF);
        snoop_write(A_END, 32'h10C, 4'hF);
        snoop_write(A_HALT, 32'd1, 4'hF);
        snoop_write(A_END, 32'h200, 4'hF);
        wait_done("basic", 200);
        check_sig("basic", 32'h100, 32'h10C);
        checks++;
        if (timeout_o !== 1'b0 || cycle_cnt_o !== 32'd3) begin
            failures++;
            $display("FAIL basic_status: to=%0b cnt=%0d, required to=0 cnt=3", timeout_o, cycle_cnt_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset("timeout");
        snoop_write(A_START, 32'h0, 4'hF);
        snoop_write(A_END, 32'h8, 4'hF);
        n = 2;
        while (n < TO - 2) begin @(posedge clk); #1; n++; end
        checks++;
        if (timeout_o !== 1'b0 || cycle_cnt_o !== 32'(TO - 2)) begin
            failures++;
            $display("FAIL timeout_early: to=%0b cnt=%0d, required to=0 cnt=%0d", timeout_o, cycle_cnt_o, TO - 2);
        end
        @(posedge clk); #1;
        checks++;
        if (timeout_o !== 1'b1 || cycle_cnt_o !== 32'(TO - 1) || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL timeout_fire: to=%0b cnt=%0d req=%0b addr=%0h, required to=1 cnt=%0d req=1 addr=0",
                     timeout_o, cycle_cnt_o, mem_req_o, mem_addr_o, TO - 1);
        end
        checks++;
        if (nd_timeout_o !== 1'b1 || nd_done_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_nodump_done: to=%0b done=%0b, required to=1 done=1", nd_timeout_o, nd_done_o);
        end
        wait_done("timeout", 200);
        check_sig("timeout", 32'h0, 32'h8);
        checks++;
        if (nd_req != 0 || cycle_cnt_o !== 32'(TO - 1) || timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_after: nd_reads=%0d cnt=%0d to=%0b, required nd_reads=0 cnt=%0d to=1", nd_req, cycle_cnt_o, timeout_o, TO - 1);
        end
    endtask

    task automatic test_halt_at_timeout();
        int n;
        do_reset("halt_at_to");
        snoop_write(A_START, 32'h0, 4'hF);
        snoop_write(A_END, 32'h4, 4'hF);
        n = 2;
        while (n < TO - 2) begin @(posedge clk); #1; n++; end
        snoop_write(A_HALT, 32'd1, 4'hF);
        checks++;
        if (timeout_o !== 1'b0 || mem_req_o !== 1'b1 || cycle_cnt_o !== 32'(TO - 1) || nd_timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL halt_at_to: to=%0b req=%0b cnt=%0d nd_to=%0b, required to=0 req=1 cnt=%0d nd_to=0",
                     timeout_o, mem_req_o, cycle_cnt_o, nd_timeout_o, TO - 1);
        end
        wait_done("halt_at_to", 200);
        check_sig("halt_at_to", 32'h0, 32'h4);
    endtask

    task automatic test_empty();
        do_reset("empty");
        snoop_write(A_START, 32'h200, 4'hF);
        snoop_write(A_END, 32'h200, 4'hF);
        snoop_write(A_HALT, 32'd1, 4'hF);
        checks++;
        if (done_o !== 1'b1 || req_q.size() != 0 || mem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL empty_done: done=%0b reads=%0d req=%0b, required done=1 reads=0 req=0", done_o, req_q.size(), mem_req_o);
        end
    endtask

    task automatic test_ready_stall();
        rdy_delay = 5; mem_lat = 3;
        do_reset("stall");
        snoop_write(A_START, 32'h40, 4'hF);
        snoop_write(A_END, 32'h4C, 4'hF);
        snoop_write(A_HALT, 32'd1, 4'hF);
        wait_done("stall", 400);
        check_sig("stall", 32'h40, 32'h4C);
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL stall_stable: unstable_cycles=%0d, required 0", stab_err);
        end
        rdy_delay = 0; mem_lat = 1;
    endtask

    task automatic test_reset_mid_dump();
        int n;
        rdy_delay = 2; mem_lat = 2;
        do_reset("middump_pre");
        snoop_write(A_START, 32'h80, 4'hF);
        snoop_write(A_END, 32'h90, 4'hF);
        snoop_write(A_HALT, 32'd1, 4'hF);
        n = 0;
        while (got_d.size() < 1 && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (got_d.size() < 1) begin
            failures++;
            $display("FAIL middump_first: words=%0d, required 1", got_d.size());
        end
        @(posedge clk); #1;
        do_reset("middump");
        snoop_write(A_START, 32'h80, 4'hF);
        snoop_write(A_END, 32'h90, 4'hF);
        snoop_write(A_HALT, 32'd1, 4'hF);
        wait_done("middump", 400);
        check_sig("middump", 32'h80, 32'h90);
        rdy_delay = 0; mem_lat = 1;
    endtask

    task automatic test_ignored_halt();
        do_reset("ign_halt");
        snoop_write(A_START, 32'h10, 4'hF);
        snoop_write(A_START, 32'h40, 4'b0011);
        snoop_write(A_END, 32'h18, 4'hF);
        snoop_write(A_HALT, 32'd2, 4'hF);
        snoop_write(A_HALT, 32'd1, 4'b0001);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0 || req_q.size() != 0 || cycle_cnt_o !== 32'd8) begin
            failures++;
            $display("FAIL ign_halt_run: done=%0b reads=%0d cnt=%0d, required done=0 reads=0 cnt=8", done_o, req_q.size(), cycle_cnt_o);
        end
        snoop_write(A_HALT, 32'd1, 4'hF);
        wait_done("ign_halt", 200);
        check_sig("ign_halt", 32'h10, 32'h18);
    endtask

    task automatic test_random();
        logic [31:0] s, e;
        for (int it = 0; it < 8; it++) begin
            seed = $urandom;
            rdy_delay = $urandom_range(0, 3);
            mem_lat = $urandom_range(1, 4);
            s = 32'($urandom_range(0, 40) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) e = 32'($urandom_range(0, int'(s)));
            else e = (s & ~32'd3) + 32'($urandom_range(1, 6) * 4) + 32'($urandom_range(0, 3));
            do_reset("random");
            snoop_write(32'($urandom_range(0, 4095) * 4), $urandom, 4'hF);
            if ($urandom_range(0, 1) == 1) begin
                snoop_write(A_START, s, 4'hF);
                snoop_write(A_END, e, 4'hF);
            end else begin
                snoop_write(A_END, e, 4'hF);
                snoop_write(A_START, s, 4'hF);
            end
            snoop_write(A_HALT, 32'd1, 4'hF);
            wait_done("random", 400);
            check_sig("random", s, e);
        end
        rdy_delay = 0; mem_lat = 1;
    endtask

    initial begin
        rst = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_timeout();
        test_halt_at_timeout();
        test_empty();
        test_ready_stall();
        test_reset_mid_dump();
        test_ignored_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jedro_1_sig_monitor.md
JEDRO_1_SIG_MONITOR -- requirements
Module: jedro_1_sig_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/snoop word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_SIZE_WORDS, default 1<<19, memory depth; control cells at word MEM_SIZE_WORDS-1 (SIG_START), -2 (SIG_END), -3 (HALT).
REQ-004 SHALL have parameter TIMEOUT, default 1000000, run cycles before forced stop.
REQ-005 SHALL have parameter DUMP_ON_TIMEOUT, default 1; 1 = dump signature after timeout, 0 = go straight to DONE.
REQ-006 clk_i  in  1  sole clock, rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 snoop_stb_i  in  1  data-bus strobe; snoop_we_i  in  4  byte write enables.
REQ-009 snoop_addr_i  in  ADDR_WIDTH  byte address; snoop_wdata_i  in  DATA_WIDTH  write data.
REQ-010 mem_req_o  out  1  read request; mem_addr_o  out  ADDR_WIDTH  read byte address.
REQ-011 mem_rvalid_i  in  1  read data valid; mem_rdata_i  in  DATA_WIDTH  read data.
REQ-012 sig_valid_o  out  1; sig_ready_i  in  1; sig_data_o  out  DATA_WIDTH; sig_last_o  out  1  signature word stream.
REQ-013 done_o  out  1  dump complete (sticky); timeout_o  out  1  timeout occurred (sticky).
REQ-014 cycle_cnt_o  out  32  run cycles counted since reset release.

Function
REQ-015 States: RUN, DUMP_REQ, DUMP_WAIT, DUMP_OUT, DONE.
REQ-016 In RUN, snoop write = snoop_stb_i && snoop_we_i==4'b1111; partial writes to control cells ignored.
REQ-017 Snoop write to SIG_START / SIG_END cell loads start_q / end_q with snoop_wdata_i, bits [1:0] forced to 0.
REQ-018 Snoop write of value 1 to HALT cell: next cycle in DUMP_REQ (or DONE if start_q>=end_q); other values ignored.
REQ-019 cycle_cnt_o increments each RUN cycle, saturates, frozen outside RUN.
REQ-020 When cycle_cnt_o reaches TIMEOUT-1 in RUN without halt: timeout_o=1, then DUMP_REQ if DUMP_ON_TIMEOUT=1 and start_q<end_q, else DONE.
REQ-021 Halt write in same cycle as timeout expiry: halt wins, timeout_o stays 0.
REQ-022 DUMP_REQ: mem_req_o=1, mem_addr_o=ptr_q (initialised to start_q); one cycle, then DUMP_WAIT.
REQ-023 DUMP_WAIT: wait any number of cycles for mem_rvalid_i; on it capture mem_rdata_i into sig_data_o, go DUMP_OUT.
REQ-024 At most one read outstanding; mem_rvalid_i outside DUMP_WAIT ignored.
REQ-025 DUMP_OUT: sig_valid_o=1, sig_data_o stable until sig_ready_i; sig_last_o=1 when ptr_q+4>=end_q.
REQ-026 On handshake: ptr_q+=4; if last go DONE, else DUMP_REQ; end address exclusive.
REQ-027 Snoop writes ignored outside RUN; start_q/end_q frozen once dump begins.
REQ-028 DONE: done_o=1, all handshake outputs 0, remains until reset.
REQ-029 Address arithmetic ADDR_WIDTH bits, wrap-around not expected; start_q>=end_q yields zero words.

Reset
REQ-030 rst_i asserted, any state incl. mid-dump: state=RUN, start_q=end_q=ptr_q=0, cycle_cnt_o=0, all outputs 0, effective immediately.
REQ-031 First RUN cycle counted is first rising edge after rst_i deasserts.

Structure
REQ-032 Package jedro_1_sig_monitor_pkg holds state enum and control-cell offset localparams (SIG_START_OFS=1, SIG_END_OFS=2, HALT_OFS=3).
REQ-033 Single sub-module jedro_1_sig_monitor_cnt: saturating cycle counter with enable, clear, and terminal-count flag.

Verification
REQ-034 Write START=0x100, END=0x10C, HALT=1; memory words 0xA,0xB,0xC -> three stream words 0xA,0xB,0xC, last on third, done_o=1, timeout_o=0.
REQ-035 TIMEOUT=50, no halt, START=0x0, END=0x8 -> timeout_o=1 at cycle 49, two words dumped, done_o=1; with DUMP_ON_TIMEOUT=0 -> zero words, done_o=1.
REQ-036 HALT=1 with START=END=0x200 -> no mem_req_o, done_o=1 one cycle after halt write.
REQ-037 sig_ready_i low 5 cycles, mem_rvalid_i 3 cycles after request -> sig_data_o stable, no extra mem_req_o.
REQ-038 rst_i pulsed mid-dump after first word -> all outputs 0 immediately; rerun dumps full signature from start.
REQ-039 HALT write value 2, and byte write (we=4'b0001) of 1 to HALT -> stays in RUN.
